// File: rtl/act_skew_feeder.sv
// act_skew_feeder: turns one accepted activation vector per handshake into the diagonal
// wavefront the systolic pe rows expect; row r sees element r exactly r+1 edges later.
module act_skew_feeder #(
  parameter int ACT_WIDTH = 16,
  parameter int NUM_ROWS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [NUM_ROWS*ACT_WIDTH-1:0] in_data,
  output logic [NUM_ROWS*ACT_WIDTH-1:0] out_a,
  output logic [NUM_ROWS-1:0]           out_row_valid,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          beat_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam int FC_WIDTH = (NUM_ROWS > 2) ? $clog2(NUM_ROWS - 1) : 1;
  localparam logic [FC_WIDTH-1:0]  FLUSH_LOAD = FC_WIDTH'((NUM_ROWS >= 2) ? NUM_ROWS - 2 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [1:0]          state;
  logic [FC_WIDTH-1:0] flush_cnt;
  logic                hs;

  assign in_ready = (state != ST_FLUSH);
  assign busy     = (state != ST_IDLE);
  assign hs       = in_valid && in_ready;

  // The flush counter runs until the last element has walked down to the bottom row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_STREAM: begin
          if (hs) begin
            if (!in_last) begin
              state <= ST_STREAM;
            end else if (NUM_ROWS > 1) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FC_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_count <= '0;
    end else if (hs) begin
      if (state == ST_IDLE) begin
        beat_count <= CNT_WIDTH'(1);
      end else if (beat_count != CNT_MAX) begin
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
    end
  end

  // Chains never stall: the array is free-running, so a bubble becomes a zero on the wire.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [ACT_WIDTH-1:0] data_q [0:r];
    logic [r:0]           valid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i <= r; i++) begin
          data_q[i] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= hs ? in_data[r*ACT_WIDTH +: ACT_WIDTH] : '0;
        valid_q[0] <= hs;
        for (int i = 1; i <= r; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign out_a[r*ACT_WIDTH +: ACT_WIDTH] = data_q[r];
    assign out_row_valid[r]                = valid_q[r];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: directed stimulus against a history-based model of the skew feeder,
// plus a NUM_ROWS=1 / CNT_WIDTH=2 instance for the boundary cases.
module tb_act_skew_feeder;

  localparam int W    = 16;
  localparam int NR   = 4;
  localparam int MAXE = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_last, in_ready, busy, done;
  logic [NR*W-1:0] in_data, out_a;
  logic [NR-1:0] out_row_valid;
  logic [15:0]   beat_count;

  logic          v1, l1, in_ready1, busy1, done1;
  logic [W-1:0]  d1, out_a1;
  logic [0:0]    orv1;
  logic [1:0]    beat1;

  always #5 clk = ~clk;

  act_skew_feeder #(.ACT_WIDTH(W), .NUM_ROWS(NR), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .out_a(out_a), .out_row_valid(out_row_valid), .busy(busy),
    .done(done), .beat_count(beat_count)
  );

  act_skew_feeder #(.ACT_WIDTH(W), .NUM_ROWS(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(in_ready1), .in_last(l1),
    .in_data(d1), .out_a(out_a1), .out_row_valid(orv1), .busy(busy1),
    .done(done1), .beat_count(beat1)
  );

  int errors = 0;
  int checks = 0;

  // Model: remember every accepted vector by edge index; outputs are read off that history.
  int edge_n    = 0;
  int rst_mark  = -1;
  int last_edge = -1000;
  bit in_frame  = 1'b0;
  int m_cnt     = 0;
  bit              hs_at  [MAXE];
  logic [NR*W-1:0] dat_at [MAXE];

  function automatic bit m_flushing(int e);
    return (e - last_edge >= 0) && (e - last_edge <= NR - 2);
  endfunction

  always @(posedge clk) begin
    bit busy_before, hs;
    if (!reset) begin
      rst_mark  = edge_n;
      last_edge = -1000;
      in_frame  = 1'b0;
      m_cnt     = 0;
    end else if (edge_n < MAXE) begin
      busy_before = in_frame || m_flushing(edge_n - 1);
      hs          = in_valid && !m_flushing(edge_n - 1);
      hs_at[edge_n]  = hs;
      dat_at[edge_n] = in_data;
      if (hs) begin
        if (!busy_before) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt++;
        if (in_last) begin
          last_edge = edge_n;
          in_frame  = 1'b0;
        end else begin
          in_frame = 1'b1;
        end
      end
    end
    edge_n++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    int e;
    logic [NR*W-1:0] ea;
    logic [NR-1:0] ev;
    logic er, eb, ed;
    int ec;
    e  = edge_n - 1;
    ea = '0;
    ev = '0;
    if (!reset) begin
      er = 1'b1; eb = 1'b0; ed = 1'b0; ec = 0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        int idx;
        idx = e - r;
        if (idx > rst_mark && idx >= 0 && hs_at[idx]) begin
          ev[r] = 1'b1;
          ea[r*W +: W] = dat_at[idx][r*W +: W];
        end
      end
      er = !m_flushing(e);
      eb = in_frame || m_flushing(e);
      ed = (e - last_edge == NR - 1);
      ec = m_cnt;
    end
    checkOutput("model_out_a", out_a, ea);
    checkOutput("model_row_valid", out_row_valid, ev);
    checkOutput("model_in_ready", in_ready, er);
    checkOutput("model_busy", busy, eb);
    checkOutput("model_done", done, ed);
    checkOutput("model_beat_count", beat_count, 64'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic [NR*W-1:0] d);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    step();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    v1 = 1'b0; l1 = 1'b0; d1 = '0;

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      step();
    end
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_beat", beat_count, 0);
    checkOutput("rst_dut1_ready", in_ready1, 1);
    checkOutput("rst_dut1_beat", beat1, 0);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("release_out_a", out_a, 0);

    // Single vector: one diagonal walk
    applyStimulus(1'b1, 1'b0, 64'h4444_3333_2222_1111);
    checkOutput("skew_e0", out_a, 64'h0000_0000_0000_1111);
    checkOutput("skew_v0", out_row_valid, 4'b0001);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("skew_e1", out_a, 64'h0000_0000_2222_0000);
    checkOutput("skew_v1", out_row_valid, 4'b0010);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("skew_e2", out_a, 64'h0000_3333_0000_0000);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("skew_e3", out_a, 64'h4444_0000_0000_0000);
    checkOutput("skew_v3", out_row_valid, 4'b1000);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("skew_e4", out_a, 0);
    checkOutput("skew_busy", busy, 1);

    applyStimulus(1'b1, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA);
    checkOutput("close_ready", in_ready, 0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("close_done", done, 1);
    checkOutput("close_beat", beat_count, 2);
    checkOutput("close_row3", out_a, 64'hDDDD_0000_0000_0000);

    // Three-beat frame starting in the done cycle
    applyStimulus(1'b1, 1'b0, 64'h1004_1003_1002_1001);
    checkOutput("frame_beat1", beat_count, 1);
    applyStimulus(1'b1, 1'b0, 64'h2004_2003_2002_2001);
    applyStimulus(1'b1, 1'b1, 64'h3004_3003_3002_3001);
    checkOutput("frame_ready_k", in_ready, 0);
    checkOutput("frame_beat3", beat_count, 3);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("frame_ready_k2", in_ready, 0);
    checkOutput("frame_out_k2", out_a, 64'h2004_3003_0000_0000);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("frame_done", done, 1);
    checkOutput("frame_ready_done", in_ready, 1);
    checkOutput("frame_out_done", out_a, 64'h3004_0000_0000_0000);

    // Bubble pattern 1,1,0,1 with junk data during the bubble
    applyStimulus(1'b1, 1'b0, 64'h4003_4002_4001_4000);
    checkOutput("newframe_beat", beat_count, 1);
    applyStimulus(1'b1, 1'b0, 64'h5003_5002_5001_5000);
    applyStimulus(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 64'h7003_7002_7001_7000);
    checkOutput("bubble_valid", out_row_valid, 4'b1101);
    checkOutput("bubble_out", out_a, 64'h4003_5002_0000_7000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("bubble_done", done, 1);

    // Reset during FLUSH discards the wavefront
    applyStimulus(1'b1, 1'b1, 64'h9999_8888_7777_6666);
    applyStimulus(1'b0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_out_a", out_a, 0);
    checkOutput("midrst_valid", out_row_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", in_ready, 1);
    checkOutput("midrst_beat", beat_count, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0);

    // Back-to-back stream, then valid pokes during the flush
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'(i == 19), {$urandom, $urandom});
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0);

    // Single-row instance with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      v1 = 1'b1; l1 = 1'b0; d1 = 16'h0100 + 16'(i);
      step();
      checkOutput("r1_beat", beat1, (i < 2) ? i + 1 : 3);
      checkOutput("r1_out", out_a1, 16'h0100 + 16'(i));
      checkOutput("r1_busy", busy1, 1);
    end
    v1 = 1'b1; l1 = 1'b1; d1 = 16'hBEEF;
    step();
    checkOutput("r1_done", done1, 1);
    checkOutput("r1_ready", in_ready1, 1);
    checkOutput("r1_busy_end", busy1, 0);
    checkOutput("r1_beat_sat", beat1, 3);
    checkOutput("r1_out_last", out_a1, 16'hBEEF);
    v1 = 1'b0; l1 = 1'b0;
    step();
    checkOutput("r1_done_off", done1, 0);
    checkOutput("r1_valid_off", orv1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
